// File: rtl/clock_div_pkg.sv
// Shared definitions for the runtime-programmable clock divider:
// controller state encoding, minimum divisor and divisor clamping.
package clock_div_pkg;

    typedef enum logic [1:0] {
        STOPPED,
        RUN,
        PENDING
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_div(input int unsigned div, input int unsigned max_div);
        if (div < MIN_DIV) return MIN_DIV;
        if (div > max_div) return max_div;
        return div;
    endfunction

endpackage

// File: rtl/clock_div_core.sv
// Period counter and divided-clock generation: low for div/2 cycles, then high
// for div - div/2 cycles; a synchronous load restarts the period with a new divisor.
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int unsigned       CWIDTH   = 8,
    parameter logic [CWIDTH-1:0] INIT_DIV = CWIDTH'(MIN_DIV)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load,
    input  logic [CWIDTH-1:0] load_div,
    output logic              clk_out,
    output logic              clk_rise,
    output logic              boundary,
    output logic [CWIDTH-1:0] cur_div
);

    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] rise_cnt;

    assign rise_cnt = (cur_div >> 1) - CWIDTH'(1);
    assign boundary = run && (cnt == cur_div - CWIDTH'(1));
    assign clk_rise = run && (cnt == rise_cnt);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            cur_div <= INIT_DIV;
        end else if (load) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            cur_div <= load_div;
        end else if (!run || boundary) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt <= cnt + CWIDTH'(1);
            if (cnt == rise_cnt) clk_out <= 1'b1;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Divide-by-N clock controller: valid/ready config port, changes applied only at
// period boundaries. Optional switch counter enabled by CLOCK_DIV_CTRL_STATS_EN.
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int unsigned CWIDTH    = 8,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CWIDTH-1:0] cfg_div,
    input  logic              cfg_gate,
    output logic              clk_out,
    output logic              clk_rise,
    output logic [CWIDTH-1:0] cur_div,
    output logic              running
`ifdef CLOCK_DIV_CTRL_STATS_EN
    ,
    output logic [15:0]       switch_count
`endif
);

    localparam int unsigned       MAX_DIV  = (1 << CWIDTH) - 1;
    localparam logic [CWIDTH-1:0] INIT_DIV = CWIDTH'(clamp_div(RESET_DIV, MAX_DIV));

    state_t            state;
    logic              pend_valid;
    logic              pend_gate;
    logic [CWIDTH-1:0] pend_div;
    logic [CWIDTH-1:0] req_div;
    logic              boundary;
    logic              apply;
    logic              xfer;
    logic              run;

    // A request taken while STOPPED is held one cycle; ready stays low meanwhile
    // so the held request cannot be overwritten before it is applied.
    assign run       = (state != STOPPED);
    assign running   = run;
    assign cfg_ready = (state == RUN) || ((state == STOPPED) && !pend_valid);
    assign xfer      = cfg_valid && cfg_ready;
    assign apply     = ((state == PENDING) && boundary) || ((state == STOPPED) && pend_valid);
    assign req_div   = CWIDTH'(clamp_div(32'(cfg_div), MAX_DIV));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_gate  <= 1'b0;
            pend_div   <= INIT_DIV;
`ifdef CLOCK_DIV_CTRL_STATS_EN
            switch_count <= '0;
`endif
        end else if (apply) begin
            state      <= pend_gate ? STOPPED : RUN;
            pend_valid <= 1'b0;
`ifdef CLOCK_DIV_CTRL_STATS_EN
            if (switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
`endif
        end else if (xfer) begin
            pend_valid <= 1'b1;
            pend_gate  <= cfg_gate;
            pend_div   <= req_div;
            if (state == RUN) state <= PENDING;
        end
    end

    clock_div_core #(
        .CWIDTH   (CWIDTH),
        .INIT_DIV (INIT_DIV)
    ) u_core (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (run),
        .load     (apply),
        .load_div (pend_div),
        .clk_out  (clk_out),
        .clk_rise (clk_rise),
        .boundary (boundary),
        .cur_div  (cur_div)
    );

endmodule
